// File: rtl/bsg_link_upstream_sequencer.sv
// Bring-up / retrain sequencer for one DDR upstream link transmitter.
// Walks the transmitter through IO reset, link enable and chip reset release
// in order, and blocks the core handshake until the link is fully up.
module bsg_link_upstream_sequencer #(
    parameter int reset_cycles_p      = 16,
    parameter int enable_cycles_p     = 64,
    parameter int chip_reset_cycles_p = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       restart_i,
    output logic       link_reset_o,
    output logic       link_enable_o,
    output logic       chip_reset_o,
    output logic       link_up_o,
    output logic [1:0] state_o,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       valid_o,
    input  logic       ready_i
);

    localparam int max_ab_lp       = (reset_cycles_p > enable_cycles_p) ? reset_cycles_p : enable_cycles_p;
    localparam int max_cycles_lp   = (max_ab_lp > chip_reset_cycles_p) ? max_ab_lp : chip_reset_cycles_p;
    localparam int lg_cnt_width_lp = (max_cycles_lp < 1) ? 1 : $clog2(max_cycles_lp + 1);

    // Terminal counts: the last counter value spent in each timed state
    localparam logic [lg_cnt_width_lp-1:0] reset_last_lp  = lg_cnt_width_lp'(reset_cycles_p - 1);
    localparam logic [lg_cnt_width_lp-1:0] enable_last_lp = lg_cnt_width_lp'(enable_cycles_p - 1);
    localparam logic [lg_cnt_width_lp-1:0] chip_last_lp   = lg_cnt_width_lp'(chip_reset_cycles_p - 1);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_ENABLE = 2'd1,
        S_CORE   = 2'd2,
        S_UP     = 2'd3
    } state_e;

    state_e                     state_r;
    state_e                     state_n;
    logic [lg_cnt_width_lp-1:0] cnt_r;
    logic [lg_cnt_width_lp-1:0] cnt_n;

    // Counter advance that holds at the terminal value instead of wrapping;
    // only S_RESET can sit at its terminal count (waiting on en_i).
    function automatic logic [lg_cnt_width_lp-1:0] cnt_sat_inc(
        input logic [lg_cnt_width_lp-1:0] cnt,
        input logic [lg_cnt_width_lp-1:0] last
    );
        if (cnt == last) begin
            return cnt;
        end
        return cnt + lg_cnt_width_lp'(1);
    endfunction

    // State and counter registers; async reset lands the link in S_RESET at once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= S_RESET;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state and next-count; restart_i overrides every other transition
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        if (restart_i) begin
            state_n = S_RESET;
            cnt_n   = '0;
        end else begin
            case (state_r)
                S_RESET: begin
                    if ((cnt_r == reset_last_lp) && en_i) begin
                        state_n = S_ENABLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_sat_inc(cnt_r, reset_last_lp);
                    end
                end
                S_ENABLE: begin
                    if (cnt_r == enable_last_lp) begin
                        state_n = S_CORE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_sat_inc(cnt_r, enable_last_lp);
                    end
                end
                S_CORE: begin
                    if (cnt_r == chip_last_lp) begin
                        state_n = S_UP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_sat_inc(cnt_r, chip_last_lp);
                    end
                end
                S_UP: begin
                    cnt_n = '0;
                end
                default: begin
                    state_n = S_RESET;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Link control pins decoded purely from the state register (glitch-free,
    // no input-to-output path)
    always_comb begin
        link_reset_o  = 1'b1;
        link_enable_o = 1'b0;
        chip_reset_o  = 1'b1;
        link_up_o     = 1'b0;
        case (state_r)
            S_RESET: begin
                link_reset_o  = 1'b1;
                link_enable_o = 1'b0;
                chip_reset_o  = 1'b1;
            end
            S_ENABLE: begin
                link_reset_o  = 1'b1;
                link_enable_o = 1'b1;
                chip_reset_o  = 1'b1;
            end
            S_CORE: begin
                link_reset_o  = 1'b0;
                link_enable_o = 1'b1;
                chip_reset_o  = 1'b1;
            end
            S_UP: begin
                link_reset_o  = 1'b0;
                link_enable_o = 1'b1;
                chip_reset_o  = 1'b0;
                link_up_o     = 1'b1;
            end
            default: begin
                link_reset_o  = 1'b1;
                link_enable_o = 1'b0;
                chip_reset_o  = 1'b1;
                link_up_o     = 1'b0;
            end
        endcase
    end

    assign state_o = state_r;

    // Handshake gate: both directions drop together the moment the link leaves
    // S_UP, so no flit can be accepted while the link is down
    assign valid_o = valid_i & link_up_o;
    assign ready_o = ready_i & link_up_o;

endmodule

// File: tb/tb_bsg_link_upstream_sequencer.sv
// Directed bench for bsg_link_upstream_sequencer: default-parameter instance
// plus a second instance built with all dwell parameters at 1.
module tb_bsg_link_upstream_sequencer;

    logic       clk;
    logic       reset_i, en_i, restart_i, valid_i, ready_i;
    logic       link_reset_o, link_enable_o, chip_reset_o, link_up_o;
    logic [1:0] state_o;
    logic       ready_o, valid_o;

    logic       rst1, en1, restart1, valid1, ready1;
    logic       link_reset1, link_enable1, chip_reset1, link_up1;
    logic [1:0] state1;
    logic       ready_o1, valid_o1;

    int errors = 0;
    int checks = 0;

    bsg_link_upstream_sequencer dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .restart_i(restart_i),
        .link_reset_o(link_reset_o), .link_enable_o(link_enable_o),
        .chip_reset_o(chip_reset_o), .link_up_o(link_up_o), .state_o(state_o),
        .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    bsg_link_upstream_sequencer #(
        .reset_cycles_p(1), .enable_cycles_p(1), .chip_reset_cycles_p(1)
    ) dut1 (
        .clk_i(clk), .reset_i(rst1), .en_i(en1), .restart_i(restart1),
        .link_reset_o(link_reset1), .link_enable_o(link_enable1),
        .chip_reset_o(chip_reset1), .link_up_o(link_up1), .state_o(state1),
        .valid_i(valid1), .ready_o(ready_o1), .valid_o(valid_o1), .ready_i(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected control pins for a given state of the default instance
    task automatic chk_ctl(input string tag, input int s);
        chk({tag, ".state"}, int'(state_o), s);
        chk({tag, ".link_reset"}, int'(link_reset_o), (s < 2) ? 1 : 0);
        chk({tag, ".link_enable"}, int'(link_enable_o), (s != 0) ? 1 : 0);
        chk({tag, ".chip_reset"}, int'(chip_reset_o), (s != 3) ? 1 : 0);
        chk({tag, ".link_up"}, int'(link_up_o), (s == 3) ? 1 : 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected state k edges after reset release / restart edge, en_i held high
    function automatic int seq_state(input int k);
        if (k < 16) return 0;
        if (k < 80) return 1;
        if (k < 112) return 2;
        return 3;
    endfunction

    initial begin
        reset_i = 1'b1; en_i = 1'b1; restart_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        rst1 = 1'b1; en1 = 1'b1; restart1 = 1'b0; valid1 = 1'b1; ready1 = 1'b1;

        // Reset values while reset_i is held
        tick; tick;
        chk_ctl("rst", 0);
        chk("rst.valid_o", int'(valid_o), 0);
        chk("rst.ready_o", int'(ready_o), 0);

        // Full bring-up with defaults: ENABLE @16, CORE @80, UP @112
        @(negedge clk) reset_i = 1'b0;
        for (int k = 1; k <= 112; k++) begin
            tick;
            chk("bringup.state", int'(state_o), seq_state(k));
            if (k == 16 || k == 80 || k == 112) chk_ctl("bringup.edge", seq_state(k));
        end
        chk("up.valid_o", int'(valid_o), 1);
        chk("up.ready_o", int'(ready_o), 1);

        // Gating is a combinational through-path in S_UP
        valid_i = 1'b0; #1;
        chk("up.valid_o_low", int'(valid_o), 0);
        ready_i = 1'b0; #1;
        chk("up.ready_o_low", int'(ready_o), 0);
        valid_i = 1'b1; ready_i = 1'b1; #1;
        chk("up.valid_o_back", int'(valid_o), 1);

        // Restart from S_UP: handshake drops immediately after the edge
        restart_i = 1'b1; tick; restart_i = 1'b0;
        chk_ctl("restart", 0);
        chk("restart.valid_o", int'(valid_o), 0);
        chk("restart.ready_o", int'(ready_o), 0);
        for (int k = 1; k <= 112; k++) begin
            tick;
            chk("reseq.state", int'(state_o), seq_state(k));
        end
        chk("reseq.valid_o", int'(valid_o), 1);

        // en_i low: FSM waits in S_RESET, leaves on first edge with en_i=1
        reset_i = 1'b1; #1;
        chk("enwait.async_state", int'(state_o), 0);
        en_i = 1'b0;
        @(negedge clk) reset_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            chk("enwait.state", int'(state_o), 0);
        end
        en_i = 1'b1;
        tick;
        chk_ctl("enwait.enter", 1);
        for (int k = 1; k <= 63; k++) tick;
        chk("enwait.enable_dwell", int'(state_o), 1);
        tick;
        chk_ctl("enwait.core", 2);

        // Restart on the same edge as ENABLE->CORE: restart wins, counter cleared
        restart_i = 1'b1; tick; restart_i = 1'b0;
        for (int k = 1; k <= 16; k++) tick;
        chk("race.enable_entered", int'(state_o), 1);
        for (int k = 1; k <= 63; k++) tick;
        chk("race.pre", int'(state_o), 1);
        restart_i = 1'b1; tick; restart_i = 1'b0;
        chk("race.state", int'(state_o), 0);
        for (int k = 1; k <= 15; k++) tick;
        chk("race.cnt_cleared", int'(state_o), 0);
        tick;
        chk("race.enable_again", int'(state_o), 1);

        // Async reset mid-S_CORE, asserted between edges
        for (int k = 1; k <= 69; k++) tick;
        chk("areset.pre", int'(state_o), 2);
        @(negedge clk);
        #2 reset_i = 1'b1;
        #1;
        chk_ctl("areset", 0);
        chk("areset.valid_o", int'(valid_o), 0);
        @(negedge clk) reset_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick;
            chk("areset.reseq", int'(state_o), seq_state(k));
        end

        // All dwell parameters = 1: states advance on consecutive edges
        @(negedge clk) rst1 = 1'b0;
        #1;
        chk("p1.state0", int'(state1), 0);
        tick;
        chk("p1.state1", int'(state1), 1);
        chk("p1.enable", int'(link_enable1), 1);
        tick;
        chk("p1.state2", int'(state1), 2);
        chk("p1.valid_o_core", int'(valid_o1), 0);
        tick;
        chk("p1.state3", int'(state1), 3);
        chk("p1.link_up", int'(link_up1), 1);
        chk("p1.chip_reset", int'(chip_reset1), 0);
        chk("p1.valid_o_up", int'(valid_o1), 1);
        chk("p1.ready_o_up", int'(ready_o1), 1);
        valid1 = 1'b0; #1;
        chk("p1.valid_o_track", int'(valid_o1), 0);
        restart1 = 1'b1; tick; restart1 = 1'b0;
        chk("p1.restart", int'(state1), 0);
        chk("p1.link_reset", int'(link_reset1), 1);
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("p1.reseq", int'(state1), k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
